// File: rtl/nsum_pkg.sv
// Shared types and default sizes for the series-sum generator.
// Holds the FSM state enum and the series-select enum.
package nsum_pkg;

    localparam int NSUM_N_W   = 4;
    localparam int NSUM_SUM_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic {
        MODE_LIN = 1'b0,
        MODE_SQR = 1'b1
    } mode_e;

endpackage

// File: rtl/nsum_term.sv
// Series term generator: k for the linear series, k*k for the square series.
// Purely combinational; the result is 2*N_W bits wide, so k*k cannot overflow.
module nsum_term
    import nsum_pkg::*;
#(
    parameter int N_W = NSUM_N_W
) (
    input  logic [N_W-1:0]   k_i,
    input  logic             mode_i,
    output logic [2*N_W-1:0] term_o
);

    logic [2*N_W-1:0] k_ext;

    // Widen k first so the square is formed at full 2*N_W precision.
    always_comb begin
        k_ext  = {{N_W{1'b0}}, k_i};
        term_o = (mode_i == MODE_SQR) ? k_ext * k_ext : k_ext;
    end

endmodule

// File: rtl/nsum_gen.sv
// Sequential series-sum generator: sum of k or k*k for k=1..N.
// Takes one term per cycle and saturates at all-ones with a sticky overflow flag.
module nsum_gen
    import nsum_pkg::*;
#(
    parameter int N_W   = NSUM_N_W,
    parameter int SUM_W = NSUM_SUM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_W-1:0]   N,
    input  logic             mode,
    input  logic             N_valid,
    output logic             N_ready,
    output logic [SUM_W-1:0] sum,
    output logic             sum_ovf,
    output logic             sum_valid,
    input  logic             sum_ready
);

    localparam int EXT_W = ((SUM_W > 2 * N_W) ? SUM_W : 2 * N_W) + 1;

    state_e           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [N_W:0]     k_q, k_d;
    logic [N_W-1:0]   n_q, n_d;
    mode_e            mode_q, mode_d;

    logic [2*N_W-1:0] term;
    logic [EXT_W-1:0] add_w;
    logic             sat;

    nsum_term #(
        .N_W (N_W)
    ) u_term (
        .k_i    (k_q[N_W-1:0]),
        .mode_i (mode_q),
        .term_o (term)
    );

    // Add at a width that cannot wrap, then clamp to the result width.
    always_comb begin
        add_w = EXT_W'(acc_q) + EXT_W'(term);
        sat   = add_w > EXT_W'({SUM_W{1'b1}});
    end

    // Next-state logic: accept, accumulate one term per cycle, hold result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        n_d     = n_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (N_valid) begin
                    n_d     = N;
                    mode_d  = mode_e'(mode);
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    k_d     = (N_W+1)'(1);
                    state_d = (N == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                acc_d = sat ? {SUM_W{1'b1}} : add_w[SUM_W-1:0];
                ovf_d = ovf_q | sat;
                k_d   = k_q + (N_W+1)'(1);
                if (k_q == {1'b0, n_q}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
            mode_q  <= MODE_LIN;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
        end
    end

    assign N_ready   = (state_q == IDLE);
    assign sum_valid = (state_q == DONE);
    assign sum       = acc_q;
    assign sum_ovf   = ovf_q;

endmodule
